sysid_check_master: RTL and testbench
=====================================

// Module: sysid_check_master
// PURPOSE
//  Avalon-MM read master that sequences the two-word system-ID slave at boot: reads ID (addr 0),
//  then timestamp (addr 1), and compares both against expected values. Retries on mismatch and
//  times out on a stalled slave. Result gates software/boot logic; sits between the reset
//  controller and the sysid control_slave.
// PARAMETERS
//  EXPECTED_ID    32'd0           expected word at address 0
//  EXPECTED_TS    32'd1713458669  expected word at address 1
//  TIMEOUT_CYCLES 16'd255         max waitrequest cycles per read before abort (>=1)
//  MAX_RETRIES    3               full re-read sequences after a mismatch (0..15)
// PORTS
//  clock           in   1   system clock, all logic rising-edge
//  reset           in   1   synchronous, active-high
//  start           in   1   1-cycle request to run a check; ignored while busy=1
//  busy            out  1   high from accepted start until done pulse (inclusive of done cycle: no)
//  done            out  1   1-cycle pulse when sequence ends (pass, fail or timeout)
//  pass            out  1   ID and TS both matched; valid from done, held until next start
//  timeout_err     out  1   a read exceeded TIMEOUT_CYCLES; held until next start
//  retries_used    out  4   mismatch retries consumed in last run
//  id_value        out  32  last captured addr-0 word
//  ts_value        out  32  last captured addr-1 word
//  avm_address     out  1   word address to sysid slave
//  avm_read        out  1   read strobe
//  avm_waitrequest in   1   slave stall; tie 0 for zero-wait slave
//  avm_readdata    in   32  read data, valid when avm_read=1 and avm_waitrequest=0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (busy, done, pass, timeout_err, retries_used, id/ts_value,
//   avm_address, avm_read). Reset mid-sequence aborts immediately, no done pulse.
//  FSM: IDLE, RD_ID, RD_TS, CHECK, FINISH.
//  IDLE: start=1 -> RD_ID next cycle; clear pass, timeout_err, retries_used, wait counter; busy=1.
//  RD_ID: avm_read=1, avm_address=0. Transfer completes in a cycle with avm_waitrequest=0:
//   capture avm_readdata -> id_value, clear wait counter, -> RD_TS. Zero-wait slave: 1 cycle.
//  RD_TS: same with avm_address=1; capture -> ts_value, -> CHECK.
//  Stall: each cycle with waitrequest=1 increments 16-bit wait counter; when counter reaches
//   TIMEOUT_CYCLES while still stalled: drop avm_read, set timeout_err=1, pass=0 -> FINISH.
//   avm_read/avm_address held stable throughout a stall (Avalon rule).
//  CHECK (1 cycle, avm_read=0): match = (id_value==EXPECTED_ID)&&(ts_value==EXPECTED_TS).
//   match -> pass=1, FINISH. mismatch && retries_used<MAX_RETRIES -> retries_used+1, RD_ID.
//   mismatch && retries_used==MAX_RETRIES -> pass=0, FINISH.
//  FINISH (1 cycle): done=1, busy=0; -> IDLE. start in FINISH cycle ignored.
//  Latency, zero-wait slave, match on first try: start@T0 -> RD_ID T1, RD_TS T2, CHECK T3,
//   done T4. Each retry adds 3 cycles; each stall cycle adds 1.
//  start while busy: ignored, no effect on state or results.
//  id_value/ts_value/pass/timeout_err/retries_used held after done until next accepted start.
// TESTING
//  Zero-wait slave returning 0 / 1713458669, start@T0 -> done@T4, pass=1, retries_used=0.
//  Slave returns TS=32'hDEADBEEF always -> 4 sequences, done with pass=0, retries_used=3.
//  Wrong TS on first read, correct on second -> pass=1, retries_used=1, done at T7.
//  waitrequest held high on addr 1 -> timeout_err=1, pass=0, done after 255 stall cycles.
//  waitrequest 2 cycles on each read -> address/read stable while stalled, pass=1, done@T8.
//  Reset asserted in RD_TS -> next cycle all outputs 0, IDLE; new start runs normally.

Source files
------------

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read bus between sysid_check_master and the sysid control_slave.
//   avm_address     word address (0 = ID, 1 = timestamp)
//   avm_read        read strobe
//   avm_waitrequest slave stall
//   avm_readdata    read data, valid when avm_read=1 and avm_waitrequest=0
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_check_master.sv
// Boot-time system-ID checker. Reads the ID word (addr 0) and timestamp word
// (addr 1) from the sysid slave, compares both against expected values, re-runs
// the whole read pair on mismatch up to MAX_RETRIES times and aborts a read that
// stalls for TIMEOUT_CYCLES cycles.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               one-cycle request, ignored while a check is running
//   busy, done          busy while checking; done pulses one cycle at the end
//   pass, timeout_err   result flags, held until the next accepted start
//   retries_used        mismatch retries consumed in the last run
//   id_value, ts_value  last captured words
//   avm                 Avalon-MM read master port
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1713458669,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout_err,
  output logic [3:0]           retries_used,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  sysid_check_master_if.master avm
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FINISH} state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        reading, xfer, stall, tmo, match, retry_ok;

  assign reading  = (state == RD_ID) || (state == RD_TS);
  assign xfer     = reading && !avm.avm_waitrequest;
  assign stall    = reading &&  avm.avm_waitrequest;
  assign wait_inc = wait_cnt + 16'd1;
  // Abort on the stall cycle that brings the count up to the limit; the strobe
  // stays asserted through that cycle and drops on the way into FINISH.
  assign tmo      = stall && (wait_inc >= TIMEOUT_CYCLES);
  assign match    = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
  assign retry_ok = retries_used < 4'(MAX_RETRIES);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = RD_ID;
      RD_ID:  if (xfer) state_nxt = RD_TS;
              else if (tmo) state_nxt = FINISH;
      RD_TS:  if (xfer) state_nxt = CHECK;
              else if (tmo) state_nxt = FINISH;
      CHECK:  if (match) state_nxt = FINISH;
              else if (retry_ok) state_nxt = RD_ID;
              else state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; address/read stay put for the whole of a stall
  // because they depend only on the state, which does not move while stalled.
  always_comb begin
    busy            = (state == RD_ID) || (state == RD_TS) || (state == CHECK);
    done            = (state == FINISH);
    avm.avm_read    = reading;
    avm.avm_address = (state == RD_TS);
  end

  // Result / capture registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pass         <= 1'b0;
      timeout_err  <= 1'b0;
      retries_used <= 4'd0;
      id_value     <= 32'd0;
      ts_value     <= 32'd0;
      wait_cnt     <= 16'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pass         <= 1'b0;
          timeout_err  <= 1'b0;
          retries_used <= 4'd0;
          wait_cnt     <= 16'd0;
        end
        RD_ID, RD_TS: begin
          if (xfer) begin
            if (state == RD_ID) id_value <= avm.avm_readdata;
            else                ts_value <= avm.avm_readdata;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_inc;
            if (tmo) begin
              timeout_err <= 1'b1;
              pass        <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (match)         pass         <= 1'b1;
          else if (retry_ok) retries_used <= retries_used + 4'd1;
          else               pass         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
module tb_sysid_check_master;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1713458669;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout_err;
  logic [3:0]  retries_used;
  logic [31:0] id_value, ts_value;

  sysid_check_master_if bus ();

  sysid_check_master dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .pass(pass), .timeout_err(timeout_err), .retries_used(retries_used),
    .id_value(id_value), .ts_value(ts_value), .avm(bus.master)
  );

  always #5 clock = ~clock;

  // Slave model: fixed wait states per address, TS word may differ on first read.
  logic [31:0] s_id = 32'd0, s_ts_first = 32'd0, s_ts_later = 32'd0;
  int          s_ws_id = 0, s_ws_ts = 0;
  int          stall_cnt, ts_reads;
  int          cur_ws;

  always_comb begin
    cur_ws = bus.avm_address ? s_ws_ts : s_ws_id;
    bus.avm_waitrequest = bus.avm_read && (stall_cnt < cur_ws);
    bus.avm_readdata = bus.avm_address ? ((ts_reads == 0) ? s_ts_first : s_ts_later) : s_id;
  end

  always @(posedge clock) begin
    if (reset || start) begin
      stall_cnt <= 0;
      ts_reads  <= 0;
    end else if (bus.avm_read) begin
      if (bus.avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt <= 0;
        if (bus.avm_address) ts_reads <= ts_reads + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] id_word, ts_first, ts_later;
    int          ws_id, ws_ts;
    int          exp_cyc;
    logic        exp_pass, exp_tmo;
    logic [3:0]  exp_ret;
    logic [31:0] exp_id, exp_ts;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    logic stable, prev_stall, prev_addr;
    s_id = v.id_word; s_ts_first = v.ts_first; s_ts_later = v.ts_later;
    s_ws_id = v.ws_id; s_ws_ts = v.ws_ts;
    @(negedge clock); start = 1'b1;           // T0
    @(negedge clock); start = 1'b0; cyc = 1;  // T1
    chk({v.name, " busy_t1"}, 32'(busy), 32'd1);
    stable = 1'b1; prev_stall = 1'b0; prev_addr = 1'b0;
    while (!done && cyc < 2000) begin
      if (prev_stall && !(bus.avm_read && bus.avm_address == prev_addr)) stable = 1'b0;
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      @(negedge clock); cyc++;
    end
    chk({v.name, " done_cycle"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({v.name, " pass"}, 32'(pass), 32'(v.exp_pass));
    chk({v.name, " timeout_err"}, 32'(timeout_err), 32'(v.exp_tmo));
    chk({v.name, " retries_used"}, 32'(retries_used), 32'(v.exp_ret));
    chk({v.name, " id_value"}, id_value, v.exp_id);
    chk({v.name, " ts_value"}, ts_value, v.exp_ts);
    chk({v.name, " bus_stable"}, 32'(stable), 32'd1);
    @(negedge clock);
    chk({v.name, " done_one_pulse"}, 32'(done), 32'd0);
    chk({v.name, " pass_held"}, 32'(pass), 32'(v.exp_pass));
  endtask

  vec_t vecs[6];

  initial begin
    //        name        id       ts_first       ts_later       wid wts  cyc pass tmo ret exp_id    exp_ts
    vecs[0] = '{"match",   EXP_ID, EXP_TS,        EXP_TS,        0,  0,    4, 1,  0,  0, EXP_ID,   EXP_TS};
    vecs[1] = '{"bad_ts",  EXP_ID, 32'hDEADBEEF,  32'hDEADBEEF,  0,  0,   13, 0,  0,  3, EXP_ID,   32'hDEADBEEF};
    vecs[2] = '{"retry1",  EXP_ID, 32'h12345678,  EXP_TS,        0,  0,    7, 1,  0,  1, EXP_ID,   EXP_TS};
    vecs[3] = '{"tmo_ts",  EXP_ID, EXP_TS,        EXP_TS,        0,  1000, 257, 0, 1, 0, EXP_ID,   EXP_TS};
    vecs[4] = '{"stall2",  EXP_ID, EXP_TS,        EXP_TS,        2,  2,    8, 1,  0,  0, EXP_ID,   EXP_TS};
    vecs[5] = '{"bad_id",  32'h5,  EXP_TS,        EXP_TS,        0,  0,   13, 0,  0,  3, 32'h5,    EXP_TS};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pass", 32'(pass), 32'd0);
    chk("rst timeout", 32'(timeout_err), 32'd0);
    chk("rst retries", 32'(retries_used), 32'd0);
    chk("rst read", 32'(bus.avm_read), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start while busy and start during FINISH are both ignored
    s_id = EXP_ID; s_ts_first = EXP_TS; s_ts_later = EXP_TS; s_ws_id = 0; s_ws_ts = 0;
    @(negedge clock); start = 1'b1;   // T0
    @(negedge clock); start = 1'b0;   // T1
    @(negedge clock); start = 1'b1;   // T2 (RD_TS)
    @(negedge clock); start = 1'b0;   // T3
    @(negedge clock);                 // T4
    chk("busy_start done_t4", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clock); start = 1'b0;   // T5
    chk("finish_start busy", 32'(busy), 32'd0);
    chk("finish_start done", 32'(done), 32'd0);
    @(negedge clock);
    chk("finish_start idle", 32'(busy), 32'd0);
    chk("busy_start pass", 32'(pass), 32'd1);
    chk("busy_start retries", 32'(retries_used), 32'd0);

    // Reset while stalled in RD_TS
    s_id = 32'h1234; s_ws_ts = 1000;
    @(negedge clock); start = 1'b1;   // T0
    @(negedge clock); start = 1'b0;   // T1
    @(negedge clock);                 // T2
    @(negedge clock);                 // T3
    chk("mid id captured", id_value, 32'h1234);
    chk("mid in rd_ts", 32'(bus.avm_address), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst done", 32'(done), 32'd0);
    chk("mid_rst id", id_value, 32'd0);
    chk("mid_rst ts", ts_value, 32'd0);
    chk("mid_rst pass", 32'(pass), 32'd0);
    chk("mid_rst read", 32'(bus.avm_read), 32'd0);
    chk("mid_rst addr", 32'(bus.avm_address), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst no done", 32'(done), 32'd0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
